kamus_test_sequencer: RTL and testbench

Synthesizable, parametrised stimulus-and-check engine for kamus_core bring-up; replaces hand-timed instruction pokes in benches and FPGA smoke tests. Holds a loadable program of up to DEPTH instructions, each with an optional expected store, and sequences the core through reset and NOP settling. It then presents each instruction on the core's instruction port for HOLD_CYCLES cycles and checks the L1D write bus against the expected store. Sits between the program loader (bench or debug host) and kamus_core's l1i/l1d ports; reports pass/fail, fail count and first failing index.

---
 rtl/kamus_test_sequencer_if.sv | 51 +++++
 rtl/kamus_test_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_kamus_test_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamus_test_sequencer_if.sv
// kamus_test_sequencer_if
// Bundles the program-loader port, the kamus_core l1i/l1d side and the run
// status of the test sequencer.
//   master : program loader / core model side (drives start, program, stores)
//   slave  : the sequencer itself
// Signals:
//   start_i, prog_we_i, prog_idx_i, prog_instr_i, prog_chk_en_i,
//   prog_exp_addr_i, prog_exp_data_i, prog_len_i   - program load and run start
//   l1d_wr_en_i, l1d_addr_i, l1d_wr_data_i         - core store bus
//   core_rst_no, l1i_instr_data_o                  - core reset and instruction
//   busy_o, done_o, pass_o, fail_count_o, first_fail_idx_o - run status
interface kamus_test_sequencer_if #(
  parameter int DEPTH = 32
);
  localparam int IW = $clog2(DEPTH);

  logic          start_i;
  logic          prog_we_i;
  logic [IW-1:0] prog_idx_i;
  logic [31:0]   prog_instr_i;
  logic          prog_chk_en_i;
  logic [31:0]   prog_exp_addr_i;
  logic [31:0]   prog_exp_data_i;
  logic [IW:0]   prog_len_i;
  logic          core_rst_no;
  logic [31:0]   l1i_instr_data_o;
  logic          l1d_wr_en_i;
  logic [31:0]   l1d_addr_i;
  logic [31:0]   l1d_wr_data_i;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [7:0]    fail_count_o;
  logic [IW-1:0] first_fail_idx_o;

  modport master (
    output start_i, prog_we_i, prog_idx_i, prog_instr_i, prog_chk_en_i,
           prog_exp_addr_i, prog_exp_data_i, prog_len_i,
           l1d_wr_en_i, l1d_addr_i, l1d_wr_data_i,
    input  core_rst_no, l1i_instr_data_o, busy_o, done_o, pass_o,
           fail_count_o, first_fail_idx_o
  );

  modport slave (
    input  start_i, prog_we_i, prog_idx_i, prog_instr_i, prog_chk_en_i,
           prog_exp_addr_i, prog_exp_data_i, prog_len_i,
           l1d_wr_en_i, l1d_addr_i, l1d_wr_data_i,
    output core_rst_no, l1i_instr_data_o, busy_o, done_o, pass_o,
           fail_count_o, first_fail_idx_o
  );
endinterface

// File: rtl/kamus_test_sequencer.sv
// kamus_test_sequencer
// Stimulus-and-check engine for kamus_core bring-up. Holds a program of up to
// DEPTH instructions with optional expected stores, resets the core, settles
// it with NOPs, then presents each instruction for HOLD_CYCLES cycles while
// watching the L1D write bus. Reports pass/fail, a saturating fail count and
// the index of the first failing entry.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset (program RAM is retained)
//   bus    - kamus_test_sequencer_if.slave (program load, core side, status)
module kamus_test_sequencer #(
  parameter int DEPTH       = 32,
  parameter int HOLD_CYCLES = 5,
  parameter int RST_CYCLES  = 2
) (
  input logic                   clk_i,
  input logic                   rst_i,
  kamus_test_sequencer_if.slave bus
);
  localparam int IW      = $clog2(DEPTH);
  localparam int LW      = IW + 1;
  localparam int CNT_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE, S_CORE_RST, S_SETTLE, S_ISSUE, S_DONE
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Program RAM, written only while no run is in progress.
  logic [31:0] ram_instr [DEPTH];
  logic        ram_chk   [DEPTH];
  logic [31:0] ram_addr  [DEPTH];
  logic [31:0] ram_data  [DEPTH];

  always_ff @(posedge clk_i) begin
    if (bus.prog_we_i && !bus.busy_o) begin
      ram_instr[bus.prog_idx_i] <= bus.prog_instr_i;
      ram_chk[bus.prog_idx_i]   <= bus.prog_chk_en_i;
      ram_addr[bus.prog_idx_i]  <= bus.prog_exp_addr_i;
      ram_data[bus.prog_idx_i]  <= bus.prog_exp_data_i;
    end
  end

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic [LW-1:0] len_q, len_nxt;

  logic          seen_q;
  logic [31:0]   mon_addr_q, mon_data_q;

  logic          core_rst_q, core_rst_nxt;
  logic [31:0]   instr_q, instr_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          pass_q, pass_nxt;
  logic [7:0]    fail_q, fail_nxt;
  logic [IW-1:0] first_q, first_nxt;

  logic start_ok, last_entry, window_end;
  logic seen_cur, chk_fail;
  logic [31:0] addr_cur, data_cur;

  assign start_ok = bus.start_i && (state_q == S_IDLE || state_q == S_DONE) &&
                    (bus.prog_len_i != '0) && (bus.prog_len_i <= DEPTH_L);
  assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign window_end = (state_q == S_ISSUE) && (cnt_q == HOLD_LAST);

  // Store monitor view for this cycle: cleared at hold count 0, and a write in
  // the current cycle overrides whatever was latched earlier in the window.
  assign seen_cur = bus.l1d_wr_en_i | (seen_q & (cnt_q != '0));
  assign addr_cur = bus.l1d_wr_en_i ? bus.l1d_addr_i    : mon_addr_q;
  assign data_cur = bus.l1d_wr_en_i ? bus.l1d_wr_data_i : mon_data_q;
  assign chk_fail = window_end && ram_chk[idx_q] &&
                    (!seen_cur || addr_cur != ram_addr[idx_q] || data_cur != ram_data[idx_q]);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      len_q   <= len_nxt;
      if (state_q == S_ISSUE) seen_q <= seen_cur;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_ISSUE) begin
      mon_addr_q <= addr_cur;
      mon_data_q <= data_cur;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    len_nxt   = len_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_nxt = S_CORE_RST;
          cnt_nxt   = '0;
          len_nxt   = bus.prog_len_i;
        end
      end
      S_CORE_RST: begin
        if (cnt_q == RST_LAST) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == HOLD_LAST) begin
          state_nxt = S_ISSUE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      S_ISSUE: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_nxt = '0;
          if (last_entry) state_nxt = S_DONE;
          else            idx_nxt   = idx_q + IW'(1);
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // state being entered so every output changes on the same edge as the state.
  always_comb begin
    fail_nxt  = fail_q;
    first_nxt = first_q;
    if (start_ok) begin
      fail_nxt  = '0;
      first_nxt = '0;
    end else if (chk_fail) begin
      fail_nxt = sat_inc8(fail_q);
      if (fail_q == '0) first_nxt = idx_q;
    end

    instr_nxt    = (state_nxt == S_ISSUE) ? ram_instr[idx_nxt] : NOP;
    busy_nxt     = (state_nxt == S_CORE_RST) || (state_nxt == S_SETTLE) ||
                   (state_nxt == S_ISSUE);
    done_nxt     = (state_nxt == S_DONE);
    pass_nxt     = (state_nxt == S_DONE) && (fail_nxt == '0);
    core_rst_nxt = core_rst_q;
    case (state_nxt)
      S_CORE_RST:               core_rst_nxt = 1'b0;
      S_SETTLE, S_ISSUE, S_DONE: core_rst_nxt = 1'b1;
      default:                  core_rst_nxt = core_rst_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_rst_q <= 1'b0;
      instr_q    <= NOP;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= '0;
      first_q    <= '0;
    end else begin
      core_rst_q <= core_rst_nxt;
      instr_q    <= instr_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      pass_q     <= pass_nxt;
      fail_q     <= fail_nxt;
      first_q    <= first_nxt;
    end
  end

  assign bus.core_rst_no      = core_rst_q;
  assign bus.l1i_instr_data_o = instr_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.pass_o           = pass_q;
  assign bus.fail_count_o     = fail_q;
  assign bus.first_fail_idx_o = first_q;
endmodule

// File: tb/tb_kamus_test_sequencer.sv
module tb_kamus_test_sequencer;
  localparam int DEPTH = 4;
  localparam int HOLD  = 5;
  localparam int RSTC  = 2;
  localparam int IW    = $clog2(DEPTH);
  localparam int LW    = IW + 1;
  localparam int D2    = 512;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kamus_test_sequencer_if #(.DEPTH(DEPTH)) bus ();
  kamus_test_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .RST_CYCLES(RSTC)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));

  // Large instance used to push the fail counter past its saturation point.
  kamus_test_sequencer_if #(.DEPTH(D2)) bus2 ();
  kamus_test_sequencer #(.DEPTH(D2), .HOLD_CYCLES(2), .RST_CYCLES(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2));

  int total  = 0;
  int passed = 0;

  // Reference program and per-window store schedule.
  logic [31:0] m_instr [DEPTH];
  bit          m_chk   [DEPTH];
  logic [31:0] m_ea    [DEPTH];
  logic [31:0] m_ed    [DEPTH];
  bit          wm [DEPTH][HOLD];
  logic [31:0] wa [DEPTH][HOLD];
  logic [31:0] wd [DEPTH][HOLD];

  typedef struct {
    int          nwr;     // writes in the checked window (0..2)
    int          win0;    // window of the first write
    logic [31:0] a0, d0;  // first write at hold 1
    logic [31:0] a1, d1;  // second write at hold 4 of window 2
    int          inj;     // cycle to inject start+prog_we, -1 for none
    bit          exp_pass;
    int          exp_fail;
    int          exp_first;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic load(input int i, input logic [31:0] ins, input bit ce,
                      input logic [31:0] ea, input logic [31:0] ed);
    bus.prog_we_i       = 1'b1;
    bus.prog_idx_i      = IW'(i);
    bus.prog_instr_i    = ins;
    bus.prog_chk_en_i   = ce;
    bus.prog_exp_addr_i = ea;
    bus.prog_exp_data_i = ed;
    tick();
    bus.prog_we_i = 1'b0;
    m_instr[i] = ins; m_chk[i] = ce; m_ea[i] = ea; m_ed[i] = ed;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < DEPTH; k++)
      for (int h = 0; h < HOLD; h++) begin
        wm[k][h] = 1'b0; wa[k][h] = '0; wd[k][h] = '0;
      end
  endtask

  // Per entry: only the last store of its window counts; a checked entry
  // fails when there is no store or the store differs from the expectation.
  function automatic void model(input int len, output int fc, output int ff);
    bit seen;
    logic [31:0] a, d;
    fc = 0; ff = 0;
    for (int k = 0; k < len; k++) begin
      seen = 1'b0; a = '0; d = '0;
      for (int h = 0; h < HOLD; h++)
        if (wm[k][h]) begin seen = 1'b1; a = wa[k][h]; d = wd[k][h]; end
      if (m_chk[k] && (!seen || a != m_ea[k] || d != m_ed[k])) begin
        if (fc == 0) ff = k;
        if (fc < 255) fc++;
      end
    end
  endfunction

  task automatic run(input int len, input int inj, input string tag);
    int c, errs, fc, ff, k, h;
    logic [31:0] ei;
    c = 0; errs = 0;
    bus.prog_len_i = LW'(len);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    while (!bus.done_o && c < 200) begin
      k = -1; h = 0;
      if (c >= RSTC + HOLD) begin
        k = (c - RSTC - HOLD) / HOLD;
        h = (c - RSTC - HOLD) % HOLD;
      end
      if (k >= 0 && k < len && wm[k][h]) begin
        bus.l1d_wr_en_i = 1'b1; bus.l1d_addr_i = wa[k][h]; bus.l1d_wr_data_i = wd[k][h];
      end else begin
        bus.l1d_wr_en_i = 1'b0;
      end
      if (c == inj) begin
        bus.start_i = 1'b1; bus.prog_len_i = LW'(1);
        bus.prog_we_i = 1'b1; bus.prog_idx_i = '0; bus.prog_instr_i = 32'hDEADBEEF;
        bus.prog_chk_en_i = 1'b1;
      end else begin
        bus.start_i = 1'b0; bus.prog_we_i = 1'b0;
      end
      ei = (k >= 0 && k < len) ? m_instr[k] : NOP;
      if (bus.l1i_instr_data_o !== ei || bus.busy_o !== 1'b1 ||
          bus.core_rst_no !== ((c >= RSTC) ? 1'b1 : 1'b0)) errs++;
      tick();
      c++;
    end
    bus.l1d_wr_en_i = 1'b0; bus.start_i = 1'b0; bus.prog_we_i = 1'b0;
    model(len, fc, ff);
    check({tag, "_run_cycles"}, c, RSTC + HOLD * (len + 1));
    check({tag, "_seq_errors"}, errs, 0);
    check({tag, "_fail_count"}, bus.fail_count_o, fc);
    check({tag, "_first_fail"}, bus.first_fail_idx_o, ff);
    check({tag, "_pass"}, bus.pass_o, (fc == 0) ? 1 : 0);
    check({tag, "_done_state"}, {bus.busy_o, bus.core_rst_no, bus.l1i_instr_data_o == NOP},
          3'b011);
  endtask

  vec_t vecs[7];
  logic [31:0] I0, I1, I2;

  initial begin
    int c;
    bus.start_i = 0; bus.prog_we_i = 0; bus.prog_idx_i = '0; bus.prog_instr_i = '0;
    bus.prog_chk_en_i = 0; bus.prog_exp_addr_i = '0; bus.prog_exp_data_i = '0;
    bus.prog_len_i = '0; bus.l1d_wr_en_i = 0; bus.l1d_addr_i = '0; bus.l1d_wr_data_i = '0;
    bus2.start_i = 0; bus2.prog_we_i = 0; bus2.prog_idx_i = '0; bus2.prog_instr_i = '0;
    bus2.prog_chk_en_i = 0; bus2.prog_exp_addr_i = '0; bus2.prog_exp_data_i = '0;
    bus2.prog_len_i = '0; bus2.l1d_wr_en_i = 0; bus2.l1d_addr_i = '0; bus2.l1d_wr_data_i = '0;
    I0 = 32'h00100093; I1 = 32'h00200113; I2 = 32'h0020A0A3;

    //               nwr win0 a0     d0     a1     d1     inj                 pass fail first
    vecs[0] = '{1, 2, 32'h2, 32'h2, 32'h0, 32'h0, RSTC + HOLD * 2 + 1, 1'b1, 0, 0};
    vecs[1] = '{1, 2, 32'h2, 32'h3, 32'h0, 32'h0, -1, 1'b0, 1, 2};
    vecs[2] = '{0, 2, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1, 2};
    vecs[3] = '{2, 2, 32'h2, 32'h5, 32'h2, 32'h2, -1, 1'b1, 0, 0};
    vecs[4] = '{2, 2, 32'h2, 32'h2, 32'h2, 32'h5, -1, 1'b0, 1, 2};
    vecs[5] = '{1, 2, 32'h3, 32'h2, 32'h0, 32'h0, -1, 1'b0, 1, 2};
    vecs[6] = '{1, 1, 32'h2, 32'h2, 32'h0, 32'h0, -1, 1'b0, 1, 2};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_core_rst_no", bus.core_rst_no, 0);
    check("rst_instr", bus.l1i_instr_data_o, NOP);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_pass", bus.pass_o, 0);
    check("rst_fail_count", bus.fail_count_o, 0);
    check("rst_first_fail", bus.first_fail_idx_o, 0);

    load(0, I0, 1'b0, 32'h0, 32'h0);
    load(1, I1, 1'b0, 32'h0, 32'h0);
    load(2, I2, 1'b1, 32'h2, 32'h2);
    load(3, NOP, 1'b0, 32'h0, 32'h0);

    // Zero and oversize lengths must not start a run.
    bus.prog_len_i = LW'(0); bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    check("start_len0_busy", bus.busy_o, 0);
    bus.prog_len_i = LW'(5); bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    check("start_len5_busy", bus.busy_o, 0);
    check("start_len5_rst", bus.core_rst_no, 0);

    foreach (vecs[v]) begin
      clear_sched();
      if (vecs[v].nwr >= 1) begin
        wm[vecs[v].win0][1] = 1'b1; wa[vecs[v].win0][1] = vecs[v].a0; wd[vecs[v].win0][1] = vecs[v].d0;
      end
      if (vecs[v].nwr >= 2) begin
        wm[2][4] = 1'b1; wa[2][4] = vecs[v].a1; wd[2][4] = vecs[v].d1;
      end
      run(3, vecs[v].inj, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_pass", v), bus.pass_o, vecs[v].exp_pass);
      check($sformatf("vec%0d_tbl_fail", v), bus.fail_count_o, vecs[v].exp_fail);
      check($sformatf("vec%0d_tbl_first", v), bus.first_fail_idx_o, vecs[v].exp_first);
    end

    // Reset in the middle of entry 1 abandons the run; the program survives.
    clear_sched();
    wm[2][2] = 1'b1; wa[2][2] = 32'h2; wd[2][2] = 32'h2;
    bus.prog_len_i = LW'(3); bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    for (int i = 0; i < RSTC + HOLD * 2 + 2; i++) tick();
    check("mid_issue_instr", bus.l1i_instr_data_o, I1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_core_rst_no", bus.core_rst_no, 0);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_instr", bus.l1i_instr_data_o, NOP);
    check("midrst_done", bus.done_o, 0);
    run(3, -1, "rerun");

    // Every entry fails each run; the count restarts from zero every start.
    load(0, I0, 1'b1, 32'h40, 32'h1);
    load(1, I1, 1'b1, 32'h44, 32'h2);
    load(2, I2, 1'b1, 32'h48, 32'h3);
    load(3, NOP, 1'b1, 32'h4C, 32'h4);
    clear_sched();
    for (int r = 0; r < 4; r++) run(4, -1, $sformatf("allfail%0d", r));

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, $urandom, 1'($urandom_range(0, 1)), 32'h10 + 32'(4 * $urandom_range(0, 1)),
             32'($urandom_range(1, 2)));
      for (int k = 0; k < DEPTH; k++)
        for (int h = 0; h < HOLD; h++) begin
          wm[k][h] = ($urandom_range(0, 2) == 0);
          wa[k][h] = 32'h10 + 32'(4 * $urandom_range(0, 1));
          wd[k][h] = 32'($urandom_range(1, 2));
        end
      run(int'($urandom_range(1, DEPTH)), -1, $sformatf("rnd%0d", r));
    end

    // 300 failing entries in one run: the count must stop at 255.
    for (int i = 0; i < 300; i++) begin
      bus2.prog_we_i = 1'b1; bus2.prog_idx_i = 9'(i); bus2.prog_instr_i = 32'(i);
      bus2.prog_chk_en_i = 1'b1; bus2.prog_exp_addr_i = 32'h100; bus2.prog_exp_data_i = 32'h1;
      tick();
    end
    bus2.prog_we_i = 1'b0;
    bus2.prog_len_i = 10'(300); bus2.start_i = 1'b1; tick(); bus2.start_i = 1'b0;
    c = 0;
    while (!bus2.done_o && c < 1000) begin tick(); c++; end
    check("sat_run_cycles", c, 1 + 2 * 301);
    check("sat_fail_count", bus2.fail_count_o, 255);
    check("sat_first_fail", bus2.first_fail_idx_o, 0);
    check("sat_pass", bus2.pass_o, 0);

    for (int i = 0; i < 2; i++) begin
      bus2.prog_we_i = 1'b1; bus2.prog_idx_i = 9'(i); bus2.prog_chk_en_i = 1'b0;
      tick();
    end
    bus2.prog_we_i = 1'b0;
    bus2.prog_len_i = 10'(2); bus2.start_i = 1'b1; tick(); bus2.start_i = 1'b0;
    check("sat_clear_on_start", bus2.fail_count_o, 0);
    c = 0;
    while (!bus2.done_o && c < 100) begin tick(); c++; end
    check("sat_rerun_cycles", c, 1 + 2 * 3);
    check("sat_rerun_pass", bus2.pass_o, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
